// File: rtl/aes_pkg.sv
// Shared types and constants for the inverse-AES round sequencer.
package aes_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT_ADD,
      ST_SHIFT,
      ST_SUB,
      ST_ADD,
      ST_MIX,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      SEL_SHIFT  = 2'b00,
      SEL_SUB    = 2'b01,
      SEL_ADDKEY = 2'b10,
      SEL_MIX    = 2'b11
   } stage_sel_t;

   localparam logic [3:0] VALID_HDR  = 4'h7;
   localparam logic [3:0] NUM_ROUNDS = 4'd10;
   localparam logic [3:0] LAST_KEY   = 4'd10;

   // stage latencies up to 255 cycles
   localparam int TMR_W = 8;

endpackage

// File: rtl/aes_inv_round_ctrl_if.sv
// Block request and datapath-control bundle between requester and round controller.
interface aes_inv_round_ctrl_if;

   logic       start;
   logic [3:0] header;
   logic       abort;
   logic       shift_load;
   logic       sub_load;
   logic       addkey_load;
   logic       mix_load;
   logic [1:0] stage_sel;
   logic       capture;
   logic [3:0] key_sel;
   logic [3:0] round_num;
   logic       busy;
   logic       done;
   logic       invalid;

   modport master (
      output start, header, abort,
      input  shift_load, sub_load, addkey_load, mix_load,
      input  stage_sel, capture, key_sel, round_num, busy, done, invalid
   );

   modport slave (
      input  start, header, abort,
      output shift_load, sub_load, addkey_load, mix_load,
      output stage_sel, capture, key_sel, round_num, busy, done, invalid
   );

endinterface

// File: rtl/aes_inv_round_ctrl_stage_timer.sv
// Per-state latency down-counter; loaded on state entry, flags first and last cycle.
module stage_timer
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             n_rst,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   output logic             first,
   output logic             last
);

   logic [TMR_W-1:0] cnt_q;
   logic             first_q;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         cnt_q   <= '0;
         first_q <= 1'b0;
      end else if (load) begin
         cnt_q   <= load_val;
         first_q <= 1'b1;
      end else begin
         first_q <= 1'b0;
         if (cnt_q != '0)
            cnt_q <= cnt_q - TMR_W'(1);
      end
   end

   assign first = first_q;
   assign last  = (cnt_q == TMR_W'(1));

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Inverse-AES round sequencer: steps the datapath through 10 inverse rounds.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | waiting for start
// INIT_ADD  | initial add of round key 10
// SHIFT     | inverse shift rows
// SUB       | inverse substitute bytes (SUB_LATENCY cycles)
// ADD       | add round key round_num
// MIX       | inverse mix columns (skipped in round 0)
// DONE      | one-cycle completion / bad-header report
module aes_inv_round_ctrl
   import aes_pkg::*;
#(
   parameter int SUB_LATENCY   = 4,
   parameter int OTHER_LATENCY = 1
) (
   input logic                 clk,
   input logic                 n_rst,
   aes_inv_round_ctrl_if.slave bus
);

   localparam logic [TMR_W-1:0] SUB_L   = TMR_W'(SUB_LATENCY);
   localparam logic [TMR_W-1:0] OTHER_L = TMR_W'(OTHER_LATENCY);

   state_t           state_q, state_d;
   logic [3:0]       round_q, round_d;
   logic             invalid_q, invalid_d;
   logic             tmr_load, tmr_first, tmr_last;
   logic [TMR_W-1:0] tmr_val;
   logic             act;
   logic             stage_st;
   stage_sel_t       sel;
   logic [3:0]       key;
   logic             shift_ld, sub_ld, add_ld, mix_ld, cap, done_o;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q   <= ST_IDLE;
         round_q   <= '0;
         invalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         round_q   <= round_d;
         invalid_q <= invalid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      round_d   = round_q;
      invalid_d = invalid_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.abort) begin
               if (bus.header == VALID_HDR) begin
                  state_d   = ST_INIT_ADD;
                  round_d   = NUM_ROUNDS - 4'd1;
                  invalid_d = 1'b0;
               end else begin
                  state_d   = ST_DONE;
                  invalid_d = 1'b1;
               end
            end
         end
         ST_INIT_ADD: if (tmr_last) state_d = ST_SHIFT;
         ST_SHIFT:    if (tmr_last) state_d = ST_SUB;
         ST_SUB:      if (tmr_last) state_d = ST_ADD;
         ST_ADD:      if (tmr_last) state_d = (round_q == 4'd0) ? ST_DONE : ST_MIX;
         ST_MIX: begin
            if (tmr_last) begin
               state_d = ST_SHIFT;
               round_d = round_q - 4'd1;
            end
         end
         ST_DONE:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
      // abort wins over every other transition
      if (state_q != ST_IDLE && bus.abort) begin
         state_d = ST_IDLE;
         round_d = round_q;
      end
   end

   assign tmr_load = (state_d != state_q) &&
                     (state_d inside {ST_INIT_ADD, ST_SHIFT, ST_SUB, ST_ADD, ST_MIX});
   assign tmr_val  = (state_d == ST_SUB) ? SUB_L : OTHER_L;

   stage_timer u_timer (
      .clk      (clk),
      .n_rst    (n_rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .first    (tmr_first),
      .last     (tmr_last)
   );

   assign act      = !bus.abort;
   assign stage_st = state_q inside {ST_INIT_ADD, ST_SHIFT, ST_SUB, ST_ADD, ST_MIX};

   always_comb begin
      sel      = SEL_SHIFT;
      key      = 4'd0;
      shift_ld = 1'b0;
      sub_ld   = 1'b0;
      add_ld   = 1'b0;
      mix_ld   = 1'b0;
      done_o   = 1'b0;
      case (state_q)
         ST_INIT_ADD: begin
            sel    = SEL_ADDKEY;
            key    = LAST_KEY;
            add_ld = tmr_first && act;
         end
         ST_SHIFT: begin
            sel      = SEL_SHIFT;
            shift_ld = tmr_first && act;
         end
         ST_SUB: begin
            sel    = SEL_SUB;
            sub_ld = tmr_first && act;
         end
         ST_ADD: begin
            sel    = SEL_ADDKEY;
            key    = round_q;
            add_ld = tmr_first && act;
         end
         ST_MIX: begin
            sel    = SEL_MIX;
            mix_ld = tmr_first && act;
         end
         ST_DONE: done_o = act;
         default: ;
      endcase
   end

   assign cap = stage_st && tmr_last && act;

   assign bus.shift_load  = shift_ld;
   assign bus.sub_load    = sub_ld;
   assign bus.addkey_load = add_ld;
   assign bus.mix_load    = mix_ld;
   assign bus.stage_sel   = sel;
   assign bus.capture     = cap;
   assign bus.key_sel     = key;
   assign bus.round_num   = round_q;
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.done        = done_o;
   assign bus.invalid     = invalid_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: two instances (SUB_LATENCY 4 and 6) against a schedule model.
module tb_aes_inv_round_ctrl;

   typedef struct packed {
      logic [3:0] loads;   // {shift, sub, addkey, mix}
      logic       capture;
      logic [1:0] sel;
      logic [3:0] key;
      logic [3:0] round;
      logic       busy;
      logic       done;
      logic       invalid;
   } rec_t;

   logic tb_clk = 1'b0;
   logic n_rst;
   always #5 tb_clk = ~tb_clk;

   aes_inv_round_ctrl_if bus0 ();
   aes_inv_round_ctrl_if bus1 ();

   aes_inv_round_ctrl #(.SUB_LATENCY(4), .OTHER_LATENCY(1)) dut0 (
      .clk   (tb_clk),
      .n_rst (n_rst),
      .bus   (bus0.slave)
   );

   aes_inv_round_ctrl #(.SUB_LATENCY(6), .OTHER_LATENCY(1)) dut1 (
      .clk   (tb_clk),
      .n_rst (n_rst),
      .bus   (bus1.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int         sub_lat [2] = '{4, 6};
   int         m_pos   [2] = '{-1, -1};   // -1 idle, -2 bad-header done, else cycle within block
   bit         m_inv   [2] = '{0, 0};
   logic [3:0] m_round [2] = '{4'd0, 4'd0};

   int         blk_cyc [2];
   int         done_at [2];
   int         nloads  [2];
   int         ndone   [2];
   int         sub_at;
   int         gap;
   logic [3:0] keyq[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Expected outputs from the round schedule: key-10 add, 9 x (shift,sub,add,mix), shift,sub,add, done.
   function automatic rec_t exp_rec(input int sl, input int pos, input logic [3:0] idle_round,
                                    input bit inv, input bit ab);
      rec_t       r;
      int         t;
      int         len;
      int         kind;
      logic [3:0] rnd;
      r         = '0;
      r.invalid = inv;
      r.round   = idle_round;
      if (pos == -1) return r;
      r.busy = 1'b1;
      if (pos == -2) begin
         r.done = !ab;
         return r;
      end
      t = pos;
      for (int s = 0; s < 40; s++) begin
         if (s == 0) begin
            kind = 2;
            rnd  = 4'd9;
         end else begin
            kind = (s - 1) % 4;
            rnd  = 4'(9 - (s - 1) / 4);
         end
         len = (kind == 1) ? sl : 1;
         if (t < len) begin
            r.sel   = 2'(kind);
            r.round = rnd;
            r.key   = (kind == 2) ? ((s == 0) ? 4'd10 : rnd) : 4'd0;
            if (t == 0 && !ab) r.loads = 4'b1000 >> kind;
            r.capture = (t == len - 1) && !ab;
            return r;
         end
         t -= len;
      end
      r.round = 4'd0;
      r.done  = !ab;
      return r;
   endfunction

   task automatic clear_stats();
      for (int i = 0; i < 2; i++) begin
         done_at[i] = -1;
         nloads[i]  = 0;
         ndone[i]   = 0;
      end
      sub_at = -100;
      gap    = -1;
      keyq.delete();
   endtask

   task automatic step(input bit st, input logic [3:0] hdr, input bit ab, input bit rn, input bit cmp);
      rec_t a [2];
      rec_t e;
      bus0.start = st;  bus1.start = st;
      bus0.header = hdr; bus1.header = hdr;
      bus0.abort = ab;  bus1.abort = ab;
      n_rst = rn;
      #1;
      a[0] = {bus0.shift_load, bus0.sub_load, bus0.addkey_load, bus0.mix_load, bus0.capture,
              bus0.stage_sel, bus0.key_sel, bus0.round_num, bus0.busy, bus0.done, bus0.invalid};
      a[1] = {bus1.shift_load, bus1.sub_load, bus1.addkey_load, bus1.mix_load, bus1.capture,
              bus1.stage_sel, bus1.key_sel, bus1.round_num, bus1.busy, bus1.done, bus1.invalid};
      for (int i = 0; i < 2; i++) begin
         e = exp_rec(sub_lat[i], m_pos[i], m_round[i], m_inv[i], ab && (m_pos[i] != -1));
         if (cmp) chk((i == 0) ? "cycle_dut0" : "cycle_dut1", 32'(a[i]), 32'(e));
         if (a[i].done === 1'b1) begin
            ndone[i]++;
            done_at[i] = blk_cyc[i];
         end
         nloads[i] += $countones(a[i].loads);
      end
      if (a[0].loads[1] === 1'b1) keyq.push_back(a[0].key);
      if (a[0].loads[2] === 1'b1) sub_at = blk_cyc[0];
      if (a[0].capture === 1'b1 && a[0].sel == 2'b01 && gap < 0) gap = blk_cyc[0] - sub_at;
      @(posedge tb_clk);
      for (int i = 0; i < 2; i++) begin
         blk_cyc[i]++;
         if (!rn) begin
            m_pos[i]   = -1;
            m_inv[i]   = 1'b0;
            m_round[i] = 4'd0;
         end else if (m_pos[i] != -1) begin
            e = exp_rec(sub_lat[i], m_pos[i], m_round[i], m_inv[i], 1'b0);
            m_round[i] = e.round;
            if (ab || e.done) m_pos[i] = -1;
            else m_pos[i]++;
         end else if (st && !ab) begin
            blk_cyc[i] = 1;
            if (hdr == 4'h7) begin
               m_pos[i] = 0;
               m_inv[i] = 1'b0;
            end else begin
               m_pos[i] = -2;
               m_inv[i] = 1'b1;
            end
         end
      end
      @(negedge tb_clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic run_until_done(input int max);
      for (int k = 0; k < max && (ndone[0] == 0 || ndone[1] == 0); k++)
         step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog elapsed_ns=%0t limit_ns=1000000", $time);
      $fatal(1);
   end

   initial begin
      bus0.start = 1'b0; bus0.header = 4'h0; bus0.abort = 1'b0;
      bus1.start = 1'b0; bus1.header = 4'h0; bus1.abort = 1'b0;
      n_rst = 1'b0;
      blk_cyc = '{0, 0};
      clear_stats();
      @(negedge tb_clk);
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      idle(2);

      // full valid block on both latencies
      clear_stats();
      step(1'b1, 4'h7, 1'b0, 1'b1, 1'b1);
      run_until_done(120);
      chk("done_lat_d0", done_at[0], 71);
      chk("done_lat_d1", done_at[1], 91);
      chk("loads_d0", nloads[0], 40);
      chk("loads_d1", nloads[1], 40);
      chk("key_count", keyq.size(), 11);
      for (int k = 0; k < keyq.size(); k++) chk("key_seq", 32'(keyq[k]), 32'(10 - k));
      chk("sub_cap_gap", gap, 3);
      chk("invalid_valid", bus0.invalid, 1'b0);
      idle(2);

      // bad header, then a valid start clears invalid
      clear_stats();
      step(1'b1, 4'h0, 1'b0, 1'b1, 1'b1);
      idle(2);
      chk("bad_done_lat", done_at[0], 1);
      chk("bad_loads", nloads[0], 0);
      chk("bad_invalid", bus0.invalid, 1'b1);
      clear_stats();
      step(1'b1, 4'h7, 1'b0, 1'b1, 1'b1);
      chk("invalid_clr", bus0.invalid, 1'b0);
      run_until_done(120);
      chk("redo_lat_d0", done_at[0], 71);
      idle(2);

      // abort at cycle 30, then a clean block
      clear_stats();
      step(1'b1, 4'h7, 1'b0, 1'b1, 1'b1);
      idle(29);
      step(1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
      chk("abort_busy_d0", bus0.busy, 1'b0);
      chk("abort_busy_d1", bus1.busy, 1'b0);
      idle(3);
      chk("abort_ndone", ndone[0] + ndone[1], 0);
      clear_stats();
      step(1'b1, 4'h7, 1'b0, 1'b1, 1'b1);
      run_until_done(120);
      chk("post_abort_d0", done_at[0], 71);
      chk("post_abort_d1", done_at[1], 91);
      idle(2);

      // start while busy is ignored
      clear_stats();
      step(1'b1, 4'h7, 1'b0, 1'b1, 1'b1);
      idle(10);
      step(1'b1, 4'h7, 1'b0, 1'b1, 1'b1);
      run_until_done(120);
      idle(5);
      chk("busy_start_d0", ndone[0], 1);
      chk("busy_start_d1", ndone[1], 1);

      // reset mid-block discards it
      clear_stats();
      step(1'b1, 4'h7, 1'b0, 1'b1, 1'b1);
      idle(19);
      step(1'b1, 4'h7, 1'b0, 1'b0, 1'b1);
      chk("rst_busy", bus0.busy, 1'b0);
      chk("rst_round", bus0.round_num, 4'd0);
      idle(100);
      chk("rst_ndone", ndone[0] + ndone[1], 0);

      // random traffic
      for (int k = 0; k < 1500; k++) begin
         step(($urandom_range(0, 3) == 0),
              ($urandom_range(0, 1) == 1) ? 4'h7 : 4'($urandom),
              ($urandom_range(0, 59) == 0),
              ($urandom_range(0, 299) != 0),
              1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_inv_round_ctrl.md
AES_INV_ROUND_CTRL -- requirements
Module: aes_inv_round_ctrl

Interface
REQ-001 SHALL have parameter SUB_LATENCY, default 4, giving the cycles the inverse-substitute stage needs from load to valid output.
REQ-002 SHALL have parameter OTHER_LATENCY, default 1, giving the cycles the shift, add-key and mix stages each need.
REQ-003 SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  request to decrypt one block; sampled only in IDLE.
REQ-006 SHALL have port header  input  4  block header (bits 131:128 of the 132-bit block), sampled with start.
REQ-007 SHALL have port abort  input  1  synchronous cancel of the current block.
REQ-008 SHALL have port shift_load, sub_load, addkey_load, mix_load  output  1 each  stage load strobes.
REQ-009 SHALL have port stage_sel  output  2  state-register input mux: 00 shift, 01 sub, 10 addkey, 11 mix.
REQ-010 SHALL have port capture  output  1  state-register write enable.
REQ-011 SHALL have port key_sel  output  4  round-key index, 0..10.
REQ-012 SHALL have port round_num  output  4  current inverse round, 9 down to 0.
REQ-013 SHALL have ports busy, done, invalid  output  1 each  status.

Function
REQ-014 SHALL implement FSM states IDLE, INIT_ADD, SHIFT, SUB, ADD, MIX, DONE.
REQ-015 In IDLE with start=1 and header==4'h7, SHALL go to INIT_ADD, set round_num=9 and clear invalid.
REQ-016 In IDLE with start=1 and header!=4'h7, SHALL go to DONE, set invalid=1 and issue no load strobe.
REQ-017 SHALL make each stage state last L cycles: L=SUB_LATENCY for SUB and L=OTHER_LATENCY otherwise.
REQ-018 SHALL assert the stage's load strobe in the first cycle of the state only.
REQ-019 SHALL assert capture in the last cycle of the state only; with L=1 both fall in the same cycle.
REQ-020 SHALL drive stage_sel to match the current stage for the whole state.
REQ-021 SHALL sequence the stages as INIT_ADD (key_sel=10), then SHIFT, SUB, ADD, MIX.
REQ-022 On leaving MIX, SHALL decrement round_num and return to SHIFT.
REQ-023 While round_num>=1, ADD SHALL use key_sel=round_num.
REQ-024 When round_num==0, SHALL run SHIFT, SUB, ADD (key_sel=0), then DONE, skipping MIX.
REQ-025 With default parameters, SHALL take 70 stage cycles and assert done in the 71st cycle after the start-sampling edge.
REQ-026 SHALL hold done high for exactly one cycle in DONE, then return to IDLE.
REQ-027 SHALL hold invalid until the next accepted start.
REQ-028 SHALL hold busy=1 in every state except IDLE.
REQ-029 SHALL ignore start while busy.
REQ-030 On abort=1 in any non-IDLE state, SHALL go to IDLE next cycle with no done, no capture and all strobes low in that cycle.
REQ-031 abort SHALL take priority over any transition in the same cycle.
REQ-032 abort and start together in IDLE SHALL mean the start is ignored.
REQ-033 Outside their active cycles, SHALL hold key_sel and stage_sel at 0 and all strobes low.

Reset
REQ-034 With n_rst=0 at a clock edge, SHALL enter IDLE and clear the stage counter.
REQ-035 Reset SHALL force round_num=0, key_sel=0, stage_sel=0 and all strobes, capture, busy, done and invalid to 0.
REQ-036 Reset mid-block SHALL discard the block without asserting done.

Structure
REQ-037 Package aes_pkg SHALL hold the FSM state enum, the stage_sel enum, VALID_HDR=4'h7, NUM_ROUNDS=10 and LAST_KEY=10.
REQ-038 The per-state latency countdown SHALL be a sub-module stage_timer: it loads L on state entry and flags first and last cycle.

Verification
REQ-039 Reset, then start with header 7 -> strobe order INIT_ADD, then SHIFT/SUB/ADD/MIX x9, then SHIFT/SUB/ADD; 40 loads total; done exactly 71 cycles after start; invalid=0.
REQ-040 Valid block with defaults -> key_sel sequence on addkey_load is 10, 9, ..., 1, 0; sub_load pulses 1 cycle and capture follows 3 cycles later.
REQ-041 Start with header 0 -> done one cycle later, invalid=1, zero load strobes; next valid start clears invalid.
REQ-042 Abort at cycle 30 of a block -> IDLE next cycle, busy=0, no done; a fresh start then completes normally in 71 cycles.
REQ-043 n_rst=0 at cycle 20, then a start while busy -> reset zeroes all outputs; start issued mid-block is ignored (single done).
REQ-044 SUB_LATENCY=6 -> done arrives 20 cycles later than default (91 cycles).
